instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 217 +++++++++++++++++++++
 tb/tb_instr_loader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Byte-stream boot loader for an instruction memory.
//                Accepts a framed stream (LEN_HI, LEN_LO, then LEN words of
//                four big-endian bytes). Each assembled word is written to
//                the instruction memory through a single-cycle write strobe.
//                The CPU core is held in reset until the load completes.
//
//                Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//                a trailing checksum byte must equal the XOR of every
//                accepted byte from LEN_HI through the last data byte.
//                A match completes the load; a mismatch rejects it.
//
//  Ports       : clk        - single clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_data    - load-stream byte
//                in_valid   - in_data holds a valid byte
//                in_ready   - loader accepts a byte this cycle
//                restart    - synchronous pulse, abort and begin a new load
//                mem_we     - one-cycle instruction-memory write strobe
//                mem_addr   - word index of the write
//                mem_wdata  - assembled instruction word
//                cpu_rst_n  - active-low CPU reset, released on success
//                done       - load completed successfully
//                err        - load rejected
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_LEN_HI = 3'd0;
    localparam logic [2:0] c_LEN_LO = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERR    = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CHK        = 3'd3;
    // The last data word hands over to the checksum byte.
    localparam logic [2:0] c_AFTER_DATA = c_CHK;
`else
    localparam logic [2:0] c_AFTER_DATA = c_DONE;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic              r_ready_en;   // low only until the first edge out of reset
    logic [15:0]       r_len;        // word count N from the stream header
    logic [1:0]        r_byte_cnt;   // byte position inside the current word
    logic [ADDR_W-1:0] r_word_cnt;   // index of the word being assembled
    logic [WIDTH-9:0]  r_shift;      // first three bytes of the current word
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WIDTH-1:0]  r_mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic        w_state_ready;
    logic        w_accept;
    logic [15:0] w_len_n;
    logic        w_len_ok;
    logic        w_last_word;
    logic        w_word_done;
    logic [2:0]  w_state_nxt;

    always_comb begin
        w_state_ready = 1'b0;
        case (r_state)
            c_LEN_HI: w_state_ready = 1'b1;
            c_LEN_LO: w_state_ready = 1'b1;
            c_DATA:   w_state_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            c_CHK:    w_state_ready = 1'b1;
`endif
            default:  w_state_ready = 1'b0;
        endcase
    end

    assign in_ready = r_ready_en & w_state_ready;

    // A byte offered together with restart is dropped, never consumed.
    assign w_accept = in_valid & in_ready & ~restart;

    // Full length as it will be once the LEN_LO byte is taken.
    assign w_len_n  = {r_len[15:8], in_data};
    assign w_len_ok = (w_len_n != 16'd0) && (32'(w_len_n) <= 32'(DEPTH));

    // r_len is at least 1 whenever DATA is reached, so N-1 never underflows.
    assign w_last_word = (32'(r_word_cnt) == (32'(r_len) - 32'd1));

    assign w_word_done = w_accept && (r_state == c_DATA) && (r_byte_cnt == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = c_LEN_HI;
        end else if (w_accept) begin
            case (r_state)
                c_LEN_HI: w_state_nxt = c_LEN_LO;
                c_LEN_LO: w_state_nxt = w_len_ok ? c_DATA : c_ERR;
                c_DATA: begin
                    if ((r_byte_cnt == 2'd3) && w_last_word) begin
                        w_state_nxt = c_AFTER_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                c_CHK:    w_state_nxt = (in_data == r_csum) ? c_DONE : c_ERR;
`endif
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_LEN_HI;
            r_ready_en  <= 1'b0;
            r_len       <= 16'd0;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= '0;
            r_shift     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;

            // The strobe is launched from the 4th accept and lasts one cycle.
            // A restart in the strobe cycle does not touch it, so that write
            // still reaches the memory. Address and data hold afterwards.
            r_mem_we <= w_word_done;
            if (w_word_done) begin
                r_mem_addr  <= r_word_cnt;
                r_mem_wdata <= {r_shift, in_data};
            end

            if (restart) begin
                r_len      <= 16'd0;
                r_byte_cnt <= 2'd0;
                r_word_cnt <= '0;
            end else if (w_accept) begin
                case (r_state)
                    c_LEN_HI: r_len[15:8] <= in_data;
                    c_LEN_LO: r_len[7:0]  <= in_data;
                    c_DATA: begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_shift    <= {r_shift[WIDTH-17:0], in_data};
                        // Hold the index on the final word so it never wraps.
                        if ((r_byte_cnt == 2'd3) && !w_last_word) begin
                            r_word_cnt <= r_word_cnt + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over the header and every data byte; the trailing
    // checksum byte itself is not folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 8'd0;
        end else if (restart) begin
            r_csum <= 8'd0;
        end else if (w_accept && ((r_state == c_LEN_HI) || (r_state == c_LEN_LO) ||
                                  (r_state == c_DATA))) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = (r_state == c_DONE);
    assign err       = (r_state == c_ERR);
    // The core runs only after a successful load.
    assign cpu_rst_n = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. Expected memory writes
//                are queued as stimulus is driven and compared by a monitor
//                when mem_we fires; status outputs are checked per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              restart = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+WIDTH-1:0] exp_q[$];
    logic [ADDR_W+WIDTH-1:0] mon_exp;

    instr_loader #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, mon_exp[WIDTH+ADDR_W-1:WIDTH],
                             mon_exp[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_stream(input logic [127:0] bytes, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*(n-1-i) +: 8]);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [127:0] bytes, input int n);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < n; i++) x = x ^ bytes[8*i +: 8];
        return x;
    endfunction
`endif

    // Complete stream; appends the correct checksum when the feature is built.
    task automatic load(input logic [127:0] bytes, input int n, input bit gap);
        send_stream(bytes, n, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(xor_bytes(bytes, n));
`endif
    endtask

    // Restart pulse with a junk byte offered in the same cycle.
    task automatic pulse_restart;
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL restart_flags: got done/err/cpu_rst_n/in_ready=%b required 0001",
                     {done, err, cpu_rst_n, in_ready});
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, mem_we, cpu_rst_n, done, err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/we/cpu_rst_n/done/err=%b required 00000",
                     {in_ready, mem_we, cpu_rst_n, done, err});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%0d data=%h required 0/0", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        exp_q.push_back({8'd0, 32'h0000_8020});
        exp_q.push_back({8'd1, 32'h2010_0078});
        load(80'h0002_0000_8020_2010_0078, 10, 1'b0);
        // Bytes offered while DONE must be ignored.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_flags: got done/err/cpu_rst_n/in_ready=%b required 1010",
                     {done, err, cpu_rst_n, in_ready});
        end
        n_checks++;
        if (exp_q.size() != 0 || mem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_writes: got pending=%0d addr=%0d required 0/1", exp_q.size(), mem_addr);
        end
    endtask

    task automatic test_gaps;
        pulse_restart();
        exp_q.push_back({8'd0, 32'h0000_8020});
        exp_q.push_back({8'd1, 32'h2010_0078});
        load(80'h0002_0000_8020_2010_0078, 10, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL gaps_flags: got done/err/cpu_rst_n/in_ready=%b required 1010",
                     {done, err, cpu_rst_n, in_ready});
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gaps_writes: got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_len;
        pulse_restart();
        send_stream(16'h0000, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready, mem_we} !== 5'b01000) begin
            n_fail++;
            $display("FAIL len_zero: got done/err/cpu_rst_n/in_ready/we=%b required 01000",
                     {done, err, cpu_rst_n, in_ready, mem_we});
        end
        pulse_restart();
        send_stream(16'h0101, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready, mem_we} !== 5'b01000) begin
            n_fail++;
            $display("FAIL len_257: got done/err/cpu_rst_n/in_ready/we=%b required 01000",
                     {done, err, cpu_rst_n, in_ready, mem_we});
        end
    endtask

    task automatic test_restart;
        pulse_restart();
        // Six data bytes: the first word completes before the abort.
        exp_q.push_back({8'd0, 32'h1122_3344});
        send_stream(64'h0002_1122_3344_5566, 8, 1'b0);
        pulse_restart();
        exp_q.push_back({8'd0, 32'hAC12_0000});
        load(48'h0001_AC12_0000, 6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL restart_done: got done/err/cpu_rst_n/in_ready=%b required 1010",
                     {done, err, cpu_rst_n, in_ready});
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_writes: got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_restart_pending;
        pulse_restart();
        exp_q.push_back({8'd0, 32'hCAFE_F00D});
        send_stream(48'h0002_CAFE_F00D, 6, 1'b0);
        // The strobe for word 0 is on the port right now.
        pulse_restart();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_write: got pending=%0d required 0", exp_q.size());
        end
        exp_q.push_back({8'd0, 32'hAC12_0000});
        load(48'h0001_AC12_0000, 6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, exp_q.size() == 0} !== 4'b1011) begin
            n_fail++;
            $display("FAIL pending_reload: got done/err/cpu_rst_n/drained=%b required 1011",
                     {done, err, cpu_rst_n, exp_q.size() == 0});
        end
    endtask

    task automatic test_full_depth;
        logic [31:0] w;
        logic [7:0]  x;
        pulse_restart();
        x = 8'h01;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            w = {i[7:0], ~i[7:0], 8'hA5, i[7:0] ^ 8'h3C};
            exp_q.push_back({i[7:0], w});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8]);
                x = x ^ w[31-8*b -: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x);
`endif
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n} !== 3'b101 || mem_addr !== 8'd255) begin
            n_fail++;
            $display("FAIL full_depth: got done/err/cpu_rst_n=%b addr=%0d required 101/255 (x=%h)",
                     {done, err, cpu_rst_n}, mem_addr, x);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_depth_writes: got pending=%0d required 0", exp_q.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_restart();
        exp_q.push_back({8'd0, 32'hAC12_0000});
        send_stream(56'h0001_AC12_0000_BF, 7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL csum_good: got done/err/cpu_rst_n/in_ready=%b required 1010",
                     {done, err, cpu_rst_n, in_ready});
        end
        pulse_restart();
        exp_q.push_back({8'd0, 32'hAC12_0000});
        send_stream(56'h0001_AC12_0000_00, 7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, in_ready} !== 4'b0100) begin
            n_fail++;
            $display("FAIL csum_bad: got done/err/cpu_rst_n/in_ready=%b required 0100",
                     {done, err, cpu_rst_n, in_ready});
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL csum_writes: got pending=%0d required 0", exp_q.size());
        end
    endtask
`endif

    task automatic test_async_reset;
        pulse_restart();
        send_stream(32'h0002_AC12, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_we, cpu_rst_n, done, err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_flags: got ready/we/cpu_rst_n/done/err=%b required 00000",
                     {in_ready, mem_we, cpu_rst_n, done, err});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL async_mem: got addr=%0d data=%h required 0/0", mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({8'd0, 32'hAC12_0000});
        load(48'h0001_AC12_0000, 6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({done, err, cpu_rst_n, exp_q.size() == 0} !== 4'b1011) begin
            n_fail++;
            $display("FAIL async_reload: got done/err/cpu_rst_n/drained=%b required 1011",
                     {done, err, cpu_rst_n, exp_q.size() == 0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bad_len();
        test_restart();
        test_restart_pending();
        test_full_depth();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
